// File: rtl/ptmch_spi_cmd_tx.sv
// SPI mode-0 command transmitter: one frame of opcode plus 0-3 address bytes, MSB first,
// framed by chip select with programmable setup, hold and idle times.
module ptmch_spi_cmd_tx #(
  parameter int unsigned P_CLK_DIV  = 4,
  parameter int unsigned P_CS_SETUP = 2,
  parameter int unsigned P_CS_HOLD  = 2,
  parameter int unsigned P_CS_IDLE  = 4
) (
  input  logic        CLK160M,
  input  logic        RESET,
  input  logic        CMD_START,
  input  logic [7:0]  CMD_OPCODE,
  input  logic [23:0] CMD_ADDR,
  input  logic [1:0]  CMD_ADDR_BYTES,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI
);

  localparam int unsigned MAX_AB  = (P_CLK_DIV > P_CS_SETUP) ? P_CLK_DIV : P_CS_SETUP;
  localparam int unsigned MAX_CD  = (P_CS_HOLD > P_CS_IDLE) ? P_CS_HOLD : P_CS_IDLE;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned SHR_W   = 32;

  localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(P_CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(P_CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(P_CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_TC  = CNT_W'(P_CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_IDLE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BIT_W-1:0]   nbits_q, nbits_d;
  logic [SHR_W-1:0]   shreg_q, shreg_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and next-output computation; MOSI is the shift register MSB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (CMD_START) begin
          case (CMD_ADDR_BYTES)
            2'd0:    shreg_d = {CMD_OPCODE, 24'h000000};
            2'd1:    shreg_d = {CMD_OPCODE, CMD_ADDR[7:0], 16'h0000};
            2'd2:    shreg_d = {CMD_OPCODE, CMD_ADDR[15:0], 8'h00};
            default: shreg_d = {CMD_OPCODE, CMD_ADDR};
          endcase
          nbits_d = BIT_W'(8) + BIT_W'({CMD_ADDR_BYTES, 3'b000});
          bit_d   = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (cnt_q == SETUP_TC) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q != DIV_TC) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == nbits_q - BIT_W'(1)) begin
              state_d = S_CS_HOLD;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = {shreg_q[SHR_W-2:0], 1'b0};
            end
          end
        end
      end

      S_CS_HOLD: begin
        if (cnt_q == HOLD_TC) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          shreg_d = '0;
          state_d = S_CS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CS_IDLE: begin
        if (cnt_q == IDLE_TC) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CMD_BUSY = busy_q;
  assign CMD_DONE = done_q;
  assign SPI_CS   = cs_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = shreg_q[SHR_W-1];

endmodule

// File: tb/tb_ptmch_spi_cmd_tx.sv
// Scoreboard bench for ptmch_spi_cmd_tx: stimulus pushes expected frames, a bus monitor
// decodes SPI frames and DONE pulses and compares against them.
module tb_ptmch_spi_cmd_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [23:0] cmd_addr = 24'h000000;
  logic [1:0]  cmd_addr_bytes = 2'd0;
  logic        cmd_busy, cmd_done, spi_cs, spi_clk, spi_mosi;

  logic        s_start = 1'b0;
  logic [7:0]  s_opcode = 8'h00;
  logic        s_busy, s_done, s_cs, s_clk, s_mosi;

  always #5 clk = ~clk;

  ptmch_spi_cmd_tx dut (
    .CLK160M(clk), .RESET(reset), .CMD_START(cmd_start), .CMD_OPCODE(cmd_opcode),
    .CMD_ADDR(cmd_addr), .CMD_ADDR_BYTES(cmd_addr_bytes), .CMD_BUSY(cmd_busy),
    .CMD_DONE(cmd_done), .SPI_CS(spi_cs), .SPI_CLK(spi_clk), .SPI_MOSI(spi_mosi)
  );

  ptmch_spi_cmd_tx #(.P_CLK_DIV(1), .P_CS_SETUP(1), .P_CS_HOLD(1), .P_CS_IDLE(1)) dut1 (
    .CLK160M(clk), .RESET(reset), .CMD_START(s_start), .CMD_OPCODE(s_opcode),
    .CMD_ADDR(24'h000000), .CMD_ADDR_BYTES(2'd0), .CMD_BUSY(s_busy),
    .CMD_DONE(s_done), .SPI_CS(s_cs), .SPI_CLK(s_clk), .SPI_MOSI(s_mosi)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t0;
    logic [31:0] data;
    int          bits;
    int          cslen;
    int          done_off;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Bus monitor: decodes frames on the default-parameter instance and scores them.
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, hold_mosi = 1'b0;
  bit          chk_next = 1'b0, cur_valid = 1'b0, done_seen = 1'b0;
  exp_t        cur;
  int          cs_start = 0, cs_rise = 0, bits_got = 0, frames_seen = 0, done_count = 0;
  logic [31:0] data_got = '0;

  always @(negedge clk) begin
    if (chk_next) begin
      check("mosi_hold_after_rise", spi_mosi, hold_mosi);
      chk_next = 1'b0;
    end
    if (spi_cs) check("sclk_idle_while_cs_high", spi_clk, 0);
    if (p_cs && !spi_cs) begin
      if (cur_valid && cur.done_off >= 0) check("done_missing", done_seen, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        cur_valid = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        cur_valid = 1'b1;
        done_seen = 1'b0;
        check("cs_fall_latency", cyc - cur.t0, 1);
        check("busy_at_cs_fall", cmd_busy, 1);
        if (frames_seen > 0) check("cs_high_gap_ge4", int'((cyc - cs_rise) >= 4), 1);
      end
      frames_seen++;
      cs_start = cyc;
      bits_got = 0;
      data_got = '0;
    end
    if (!spi_cs && !p_sclk && spi_clk) begin
      bits_got++;
      data_got = {data_got[30:0], spi_mosi};
      check("mosi_stable_before_rise", spi_mosi, p_mosi);
      hold_mosi = spi_mosi;
      chk_next = 1'b1;
    end
    if (!p_cs && spi_cs && cur_valid) begin
      cs_rise = cyc;
      check("frame_bits", bits_got, cur.bits);
      check("frame_data", data_got, cur.data);
      check("cs_low_len", cyc - cs_start, cur.cslen);
    end else if (!p_cs && spi_cs) begin
      cs_rise = cyc;
    end
    if (cmd_done) begin
      done_count++;
      if (!cur_valid || cur.done_off < 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        check("done_cycle", cyc - cur.t0, cur.done_off);
        check("busy_low_at_done", cmd_busy, 0);
        check("done_single", done_seen, 0);
      end
      done_seen = 1'b1;
    end
    p_cs = spi_cs;
    p_sclk = spi_clk;
    p_mosi = spi_mosi;
  end

  // Issue a command at the current negedge and record its expected frame.
  task automatic start_cmd(input logic [7:0] op, input logic [23:0] addr, input logic [1:0] nb,
                           input logic [31:0] edata, input int ebits, input int ecslen,
                           input int edone);
    exp_t e;
    cmd_opcode = op;
    cmd_addr = addr;
    cmd_addr_bytes = nb;
    cmd_start = 1'b1;
    e.t0 = cyc;
    e.data = edata;
    e.bits = ebits;
    e.cslen = ecslen;
    e.done_off = edone;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_opcode = 8'hEE;
    cmd_addr = 24'hEEEEEE;
    cmd_addr_bytes = 2'd3;
  endtask

  task automatic wait_done(input int budget);
    int i;
    bit got;
    i = 0;
    got = 1'b0;
    while (i < budget && !got) begin
      @(negedge clk);
      if (cmd_done) got = 1'b1;
      i++;
    end
    check("done_within_budget", got, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"}, spi_cs, 1);
    check({tag, "_sclk"}, spi_clk, 0);
    check({tag, "_mosi"}, spi_mosi, 0);
    check({tag, "_busy"}, cmd_busy, 0);
    check({tag, "_done"}, cmd_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, low_cnt, rises, done_rel, done_n, last_rise;
    logic [7:0] d1;
    logic p1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    start_cmd(8'h02, 24'h000000, 2'd0, 32'h00000002, 8, 68, 73);
    wait_done(400);
    @(negedge clk);
    start_cmd(8'h13, 24'h00A5C3, 2'd3, 32'h1300A5C3, 32, 260, 265);
    wait_done(400);
    @(negedge clk);
    start_cmd(8'h02, 24'hFF1234, 2'd2, 32'h00021234, 24, 196, 201);
    wait_done(400);
    @(negedge clk);

    // START pulses mid-frame must be ignored.
    start_cmd(8'h9F, 24'h00005A, 2'd1, 32'h00009F5A, 16, 132, 137);
    repeat (4) @(negedge clk);
    cmd_opcode = 8'hFF;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (34) @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_done(400);

    // Back-to-back: START high in the DONE cycle.
    start_cmd(8'h05, 24'h000000, 2'd0, 32'h00000005, 8, 68, 73);
    wait_done(400);
    @(negedge clk);

    // Reset at cycle 30 of a 32-bit frame.
    start_cmd(8'h13, 24'h00A5C3, 2'd3, 32'h00000000, 3, 30, -1);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (100) @(negedge clk);

    start_cmd(8'h03, 24'h123456, 2'd3, 32'h03123456, 32, 260, 265);
    wait_done(400);
    repeat (5) @(negedge clk);
    check("done_count", done_count, 6);
    check("queue_empty", exp_q.size(), 0);
    check("final_done_seen", done_seen, 1);

    // Minimum-parameter instance: 2-cycle SCK, CS low 18 cycles, DONE at cycle 20.
    s_opcode = 8'hA5;
    s_start = 1'b1;
    t0 = cyc;
    low_cnt = 0;
    rises = 0;
    done_rel = -1;
    done_n = 0;
    last_rise = 0;
    d1 = 8'h00;
    p1 = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    s_opcode = 8'h00;
    for (int k = 0; k < 30; k++) begin
      if (!s_cs) low_cnt++;
      if (!s_cs && !p1 && s_clk) begin
        rises++;
        d1 = {d1[6:0], s_mosi};
        if (rises > 1) check("div1_sck_period", cyc - last_rise, 2);
        last_rise = cyc;
      end
      if (s_done) begin
        done_n++;
        done_rel = cyc - t0;
      end
      p1 = s_clk;
      @(negedge clk);
    end
    check("div1_cs_low_len", low_cnt, 18);
    check("div1_rises", rises, 8);
    check("div1_data", d1, 8'hA5);
    check("div1_done_cycle", done_rel, 20);
    check("div1_done_count", done_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptmch_spi_cmd_tx.md
Name: ptmch_spi_cmd_tx

Overview:
SPI mode-0 master that issues one command frame per request: an 8-bit opcode followed by 0-3 address bytes, MSB first, on SPI_CS/SPI_CLK/SPI_MOSI. It runs in the CLK160M domain and generates the frames that the PROGRAM_EXECUTE trigger monitor snoops, including opcode 8'h02. Upstream control logic drives it through a start/busy/done handshake.

Parameters:
P_CLK_DIV, 4, SPI_CLK half-period in CLK160M cycles (4 -> 20 MHz SCK); legal range >=1
P_CS_SETUP, 2, CLK160M cycles from SPI_CS low to the first SPI_CLK rising edge phase; >=1
P_CS_HOLD, 2, CLK160M cycles from the last SPI_CLK falling edge to SPI_CS high; >=1
P_CS_IDLE, 4, minimum SPI_CS-high cycles before DONE and the next frame; >=1

Ports:
CLK160M  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous reset, active-high
CMD_START  input  1  frame request, sampled only in IDLE
CMD_OPCODE  input  8  opcode, sent first
CMD_ADDR  input  24  address; low 8*CMD_ADDR_BYTES bits are sent
CMD_ADDR_BYTES  input  2  number of address bytes, 0..3
CMD_BUSY  output  1  high while a frame is in progress
CMD_DONE  output  1  one-cycle pulse at frame completion
SPI_CS  output  1  chip select, active-low
SPI_CLK  output  1  serial clock, idles low (mode 0)
SPI_MOSI  output  1  serial data out

Behaviour:
- Reset is synchronous. In the cycle after RESET is sampled high: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, CMD_BUSY=0, CMD_DONE=0, FSM=IDLE, all counters=0.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> CS_IDLE -> IDLE.
- IDLE: when CMD_START=1, latch CMD_OPCODE, CMD_ADDR and CMD_ADDR_BYTES into a 32-bit shift register. The frame is {opcode, addr[8n-1:0]} left-aligned, with n = CMD_ADDR_BYTES and bit count N = 8+8n. Enter CS_SETUP. CMD_START is ignored in every other state, and there is no queueing.
- Cycle numbering: the accept cycle is cycle 0. From cycle 1, CMD_BUSY=1.
- CS_SETUP: runs cycles 1..P_CS_SETUP with SPI_CS=0, SPI_CLK=0 and SPI_MOSI = frame MSB.
- SHIFT: each bit takes P_CLK_DIV cycles with SPI_CLK=0, then P_CLK_DIV cycles with SPI_CLK=1.
  - SPI_MOSI changes only in the first low-phase cycle of the next bit (the falling edge), so it is stable for a full half-period before each rising edge.
  - Exactly N rising edges occur. A bit counter ends the state after the high phase of bit N-1.
- CS_HOLD: P_CS_HOLD cycles with SPI_CLK=0 and SPI_CS=0. SPI_MOSI holds the last bit.
- CS_IDLE: SPI_CS=1 and SPI_MOSI=0 for P_CS_IDLE cycles.
- Completion: on the cycle after CS_IDLE, CMD_DONE=1 for one cycle, CMD_BUSY=0 and FSM=IDLE. A CMD_START in this same cycle is accepted, giving back-to-back frames.
- Timing with defaults:
  - SPI_CS is low for P_CS_SETUP + 2*P_CLK_DIV*N + P_CS_HOLD cycles: 68 for N=8, 260 for N=32.
  - CMD_DONE fires at cycle 1 + SPI_CS-low length + P_CS_IDLE: cycle 73 for N=8.
- SPI_CLK never toggles while SPI_CS=1. No glitches: all SPI outputs are driven directly from flops.
- Width rules:
  - Half-period counter is clog2(max(P_CLK_DIV, P_CS_SETUP, P_CS_HOLD, P_CS_IDLE)+1) bits, saturating at terminal count and reloaded per state.
  - Bit counter is 6 bits.
- Reset mid-frame: outputs return to reset values on the next cycle (SPI_CS high immediately). No CMD_DONE pulse, and the latched command is discarded.
- Inputs are don't-care except in the accept cycle.

Test Plan:
- Opcode 8'h02, ADDR_BYTES=0, START at cycle 0 -> SPI_CS low cycles 1..68; 8 SPI_CLK rising edges sampling 0000_0010; CMD_DONE=1 only at cycle 73; CMD_BUSY high cycles 1..72.
- Opcode 8'h13, ADDR=24'h00A5C3, ADDR_BYTES=3 -> 32 rising edges sampling 0x1300A5C3 MSB first; SPI_CS low 260 cycles; MOSI constant across each rising edge +/-1 cycle.
- ADDR_BYTES=2, ADDR=24'hFF1234 -> 24 bits 0x021234 (opcode 02); upper byte FF never appears.
- CMD_START pulsed at cycles 5 and 40 during a frame -> ignored; exactly one frame and one DONE. START held high in the DONE cycle -> second frame, SPI_CS falls the next cycle, and SPI_CS was high for >=4 cycles in between.
- RESET asserted at cycle 30 of a 32-bit frame -> cycle 31: SPI_CS=1, SPI_CLK=0, MOSI=0, BUSY=0; no DONE; a new START afterwards produces a clean full frame.
- P_CLK_DIV=1, P_CS_SETUP=P_CS_HOLD=P_CS_IDLE=1 -> SCK period 2 cycles; 8-bit frame has SPI_CS low 18 cycles and DONE at cycle 20.
